// File: rtl/spectrum_bar_animation_pkg.sv
// rtl/spectrum_bar_animation_pkg.sv - shared mode encodings, colour defaults and level saturation
package spectrum_anim_pkg;

    typedef enum logic [1:0] {
        MODE_HOME     = 2'd0,
        MODE_PARTY    = 2'd1,
        MODE_SPECTRUM = 2'd2,
        MODE_PEAK     = 2'd3
    } mode_t;

    localparam logic [47:0] HOME_COLOR_DEFAULT = 48'hB3FFFF_B3FFFF;
    localparam logic [23:0] PEAK_COLOR_DEFAULT = 24'hFFFFFF;

    // Clamp a band level to the number of rows a half-panel can show.
    function automatic int sat(input int value, input int limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/spectrum_bar_animation_if.sv
// rtl/spectrum_bar_animation_if.sv - panel driver / animation block signal bundle
interface spectrum_bar_animation_if #(
    parameter int NBANDS  = 8,
    parameter int LEVEL_W = 5,
    parameter int ADDR_W  = 9,
    parameter int COLOR_W = 24
);
    logic [NBANDS*LEVEL_W-1:0] levels;
    logic                      level_valid;
    logic [ADDR_W-1:0]         ram_address;
    logic [1:0]                mode;
    logic                      on_off;
    logic [2*COLOR_W-1:0]      ram_data;
    logic                      frame_tick;

    modport master (
        output levels, level_valid, ram_address, mode, on_off,
        input  ram_data, frame_tick
    );

    modport slave (
        input  levels, level_valid, ram_address, mode, on_off,
        output ram_data, frame_tick
    );
endinterface

// File: rtl/spectrum_bar_animation_peak_hold_cell.sv
// rtl/spectrum_bar_animation_peak_hold_cell.sv - per-band peak tracker with hold then stepped decay
module peak_hold_cell #(
    parameter int LEVEL_W  = 5,
    parameter int HOLD_FR  = 30,
    parameter int DECAY_FR = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [LEVEL_W-1:0] level,
    output logic [LEVEL_W-1:0] pk
);
    localparam int HOLD_W = $clog2(HOLD_FR + 1);
    localparam int DEC_W  = (DECAY_FR > 1) ? $clog2(DECAY_FR) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FR);
    localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECAY_FR - 1);

    logic [HOLD_W-1:0] hold;
    logic [DEC_W-1:0]  decay_cnt;

    // Once per frame: a level at or above the peak re-arms the hold; otherwise hold, then decay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pk        <= '0;
            hold      <= '0;
            decay_cnt <= '0;
        end else if (tick) begin
            if (level >= pk) begin
                pk   <= level;
                hold <= HOLD_LOAD;
            end else if (hold != '0) begin
                hold <= hold - 1'b1;
            end else if (decay_cnt == DEC_LAST) begin
                decay_cnt <= '0;
                if (pk != '0) begin
                    pk <= pk - 1'b1;
                end
            end else begin
                decay_cnt <= decay_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spectrum_bar_animation.sv
// rtl/spectrum_bar_animation.sv - mirrored per-band spectrum bars with peak markers for the LED panel
module spectrum_bar_animation
    import spectrum_anim_pkg::*;
#(
    parameter int                     COLS       = 32,
    parameter int                     ROWS_HALF  = 16,
    parameter int                     NBANDS     = 8,
    parameter int                     LEVEL_W    = 5,
    parameter int                     COLOR_W    = 24,
    parameter logic [COLOR_W-1:0]     BAND_STEP  = 24'h0A0A0A,
    parameter int                     HOLD_FR    = 30,
    parameter int                     DECAY_FR   = 4,
    parameter logic [2*COLOR_W-1:0]   HOME_COLOR = HOME_COLOR_DEFAULT,
    parameter logic [COLOR_W-1:0]     PEAK_COLOR = PEAK_COLOR_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    spectrum_bar_animation_if.slave  bus
);
    localparam int ADDR_W    = $clog2(COLS * ROWS_HALF);
    localparam int CMP_W     = ADDR_W + 1;
    localparam int BAND_COLS = COLS / NBANDS;
    localparam int BAND_IW   = (NBANDS > 1) ? $clog2(NBANDS) : 1;

    localparam logic [CMP_W-1:0] COLS_X      = CMP_W'(COLS);
    localparam logic [CMP_W-1:0] ROWS_X      = CMP_W'(ROWS_HALF);
    localparam logic [CMP_W-1:0] BAND_COLS_X = CMP_W'(BAND_COLS);

    logic [LEVEL_W-1:0] pending [NBANDS];
    logic [LEVEL_W-1:0] active  [NBANDS];
    logic [LEVEL_W-1:0] pk      [NBANDS];

    logic [ADDR_W-1:0]    prev_addr;
    logic [COLOR_W-1:0]   color_base;
    logic                 tick;
    logic                 frame_tick_q;
    logic [2*COLOR_W-1:0] ram_data_q;

    logic [CMP_W-1:0]     addr_x;
    logic [CMP_W-1:0]     row;
    logic [CMP_W-1:0]     col;
    logic [BAND_IW-1:0]   band_idx;
    mode_t                mode_sel;

    logic [LEVEL_W-1:0]   h;
    logic [LEVEL_W-1:0]   pk_b;
    logic [CMP_W-1:0]     hx;
    logic [CMP_W-1:0]     pkx;
    logic [COLOR_W-1:0]   lit_color;
    logic                 show_peak;
    logic [COLOR_W-1:0]   bottom;
    logic [COLOR_W-1:0]   top;
    logic [2*COLOR_W-1:0] next_data;

    // A new sweep starts when address 0 follows any other address; dwelling on 0 does not retrigger.
    assign tick = (bus.ram_address == '0) && (prev_addr != '0);

    assign addr_x   = {1'b0, bus.ram_address};
    assign row      = addr_x / COLS_X;
    assign col      = addr_x % COLS_X;
    assign band_idx = BAND_IW'(col / BAND_COLS_X);
    assign mode_sel = mode_t'(bus.mode);

    // Latch saturated band levels whenever the producer strobes a new set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < NBANDS; b++) begin
                pending[b] <= '0;
            end
        end else if (bus.level_valid) begin
            for (int b = 0; b < NBANDS; b++) begin
                pending[b] <= LEVEL_W'(sat(32'(bus.levels[b*LEVEL_W +: LEVEL_W]), ROWS_HALF));
            end
        end
    end

    // Frame bookkeeping: track the address, promote pending levels and advance the colour cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_addr    <= '1;
            frame_tick_q <= 1'b0;
            color_base   <= '0;
            for (int b = 0; b < NBANDS; b++) begin
                active[b] <= '0;
            end
        end else begin
            prev_addr    <= bus.ram_address;
            frame_tick_q <= tick;
            if (tick) begin
                color_base <= color_base + 1'b1;
                for (int b = 0; b < NBANDS; b++) begin
                    active[b] <= pending[b];
                end
            end
        end
    end

    for (genvar b = 0; b < NBANDS; b++) begin : g_peak
        peak_hold_cell #(
            .LEVEL_W  (LEVEL_W),
            .HOLD_FR  (HOLD_FR),
            .DECAY_FR (DECAY_FR)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .level (active[b]),
            .pk    (pk[b])
        );
    end

    // Pixel pair for the current address, built from the state before this edge's frame update.
    always_comb begin
        h         = active[band_idx];
        pk_b      = pk[band_idx];
        lit_color = color_base + COLOR_W'(band_idx) * BAND_STEP;
        if (mode_sel == MODE_PARTY) begin
            h         = active[0];
            lit_color = color_base;
        end
        hx        = CMP_W'(h);
        pkx       = CMP_W'(pk_b);
        show_peak = (mode_sel == MODE_PEAK) && (pkx > hx);
        bottom    = '0;
        top       = '0;
        if (row < hx) begin
            bottom = lit_color;
        end else if (show_peak && (row + 1'b1 == pkx)) begin
            bottom = PEAK_COLOR;
        end
        if (row + hx >= ROWS_X) begin
            top = lit_color;
        end else if (show_peak && (row + pkx == ROWS_X)) begin
            top = PEAK_COLOR;
        end
        if (mode_sel == MODE_HOME) begin
            next_data = bus.on_off ? HOME_COLOR : '0;
        end else begin
            next_data = {bottom, top};
        end
    end

    // Register the pixel so the driver sees it one cycle after presenting the address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_data_q <= '0;
        end else begin
            ram_data_q <= next_data;
        end
    end

    assign bus.ram_data   = ram_data_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_spectrum_bar_animation.sv
// tb/tb_spectrum_bar_animation.sv - randomized bench with behavioural pixel/peak model
module tb_spectrum_bar_animation;
    localparam int COLS = 32;
    localparam int RH   = 16;
    localparam int NB   = 8;
    localparam int LW   = 5;
    localparam int CW   = 24;
    localparam int AW   = 9;
    localparam logic [23:0] STEP = 24'h0A0A0A;
    localparam logic [47:0] HOME = 48'hB3FFFF_B3FFFF;
    localparam logic [23:0] PEAK = 24'hFFFFFF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spectrum_bar_animation_if #(.NBANDS(NB), .LEVEL_W(LW), .ADDR_W(AW), .COLOR_W(CW)) bus ();

    spectrum_bar_animation dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    int pend [NB];
    int act  [NB];
    int pk   [NB];
    int hold [NB];
    int dc   [NB];
    logic [23:0] cb;
    int prev;
    logic [47:0] exp_data = '0;
    logic        exp_tick = 1'b0;

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    endtask

    function automatic logic [47:0] model_pixel(input int addr, input int md, input logic onoff);
        int r, c, b, h, p;
        logic [23:0] colr, bot, top;
        if (md == 0) return onoff ? HOME : 48'h0;
        r = addr / COLS;
        c = addr % COLS;
        b = c / (COLS / NB);
        h = (md == 1) ? act[0] : act[b];
        colr = (md == 1) ? cb : cb + 24'(b) * STEP;
        p = pk[b];
        bot = '0;
        top = '0;
        if (r < h) bot = colr;
        else if (md == 3 && p > h && r == p - 1) bot = PEAK;
        if (r > RH - 1 - h) top = colr;
        else if (md == 3 && p > h && r == RH - p) top = PEAK;
        return {bot, top};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int a, v;
        bit tk;
        if (!rst_n) begin
            for (int b = 0; b < NB; b++) begin
                pend[b] = 0; act[b] = 0; pk[b] = 0; hold[b] = 0; dc[b] = 0;
            end
            cb = '0;
            prev = (1 << AW) - 1;
            exp_data = '0;
            exp_tick = 1'b0;
        end else begin
            a = int'(bus.ram_address);
            tk = (a == 0) && (prev != 0);
            exp_data = model_pixel(a, int'(bus.mode), bus.on_off);
            exp_tick = tk;
            if (tk) begin
                for (int b = 0; b < NB; b++) begin
                    if (act[b] >= pk[b]) begin
                        pk[b] = act[b];
                        hold[b] = 30;
                    end else if (hold[b] > 0) begin
                        hold[b] = hold[b] - 1;
                    end else if (dc[b] == 3) begin
                        dc[b] = 0;
                        if (pk[b] > 0) pk[b] = pk[b] - 1;
                    end else begin
                        dc[b] = dc[b] + 1;
                    end
                end
                for (int b = 0; b < NB; b++) act[b] = pend[b];
                cb = cb + 24'd1;
            end
            if (bus.level_valid) begin
                for (int b = 0; b < NB; b++) begin
                    v = int'(bus.levels[b*LW +: LW]);
                    pend[b] = (v > RH) ? RH : v;
                end
            end
            prev = a;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ram_data", bus.ram_data, exp_data);
            check("frame_tick", {47'b0, bus.frame_tick}, {47'b0, exp_tick});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic frame();
        bus.ram_address = '0;
        cyc();
        bus.ram_address = 9'd1;
        cyc();
    endtask

    task automatic strobe(input logic [NB*LW-1:0] lv);
        bus.levels = lv;
        bus.level_valid = 1'b1;
        bus.ram_address = 9'd3;
        cyc();
        bus.level_valid = 1'b0;
    endtask

    task automatic probe(input int a, input string name, input logic [47:0] want);
        bus.ram_address = AW'(a);
        cyc();
        check(name, bus.ram_data, want);
    endtask

    task automatic sweep(input int first, input int n);
        for (int a = first; a < first + n; a++) begin
            bus.ram_address = AW'(a);
            cyc();
        end
    endtask

    initial begin
        int nt;
        logic [NB*LW-1:0] lv;
        bus.levels = '0;
        bus.level_valid = 1'b0;
        bus.ram_address = '0;
        bus.mode = 2'd0;
        bus.on_off = 1'b1;
        rst_n = 1'b0;
        repeat (3) cyc();
        chk_en = 1'b1;
        rst_n = 1'b1;

        sweep(0, 100);
        check("t1_home_before_reset", bus.ram_data, HOME);
        rst_n = 1'b0;
        #1;
        check("t1_data_in_reset", bus.ram_data, 48'h0);
        check("t1_tick_in_reset", {47'b0, bus.frame_tick}, 48'h0);
        cyc();
        cyc();
        bus.ram_address = '0;
        rst_n = 1'b1;
        cyc();
        check("t1_first_tick", {47'b0, bus.frame_tick}, 48'h1);
        cyc();
        check("t1_tick_once", {47'b0, bus.frame_tick}, 48'h0);

        bus.mode = 2'd2;
        strobe({NB{5'd4}});
        sweep(0, 512);
        sweep(0, 512);
        probe(100, "t2_row3_band1", {cb + STEP, 24'h0});
        probe(128, "t2_row4_dark", 48'h0);
        probe(384, "t2_row12_top", {24'h0, cb});
        probe(383, "t2_row11_dark", 48'h0);

        lv = '0;
        lv[3*LW +: LW] = 5'd16;
        strobe(lv);
        sweep(0, 512);
        probe(12, "t3_col12_row0", {cb + 24'h1E1E1E, cb + 24'h1E1E1E});
        probe(495, "t3_col15_row15", {cb + 24'h1E1E1E, cb + 24'h1E1E1E});
        probe(11, "t3_col11_dark", 48'h0);
        probe(16, "t3_col16_dark", 48'h0);

        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        bus.mode = 2'd3;
        lv = '0;
        lv[0 +: LW] = 5'd10;
        strobe(lv);
        frame();
        strobe('0);
        frame();
        probe(288, "t4_peak_bottom_row9", {PEAK, 24'h0});
        probe(192, "t4_peak_top_row6", {24'h0, PEAK});
        repeat (33) frame();
        probe(288, "t4_peak_still_held", {PEAK, 24'h0});
        frame();
        probe(256, "t4_first_decay_row8", {PEAK, 24'h0});
        probe(288, "t4_row9_cleared", 48'h0);
        repeat (4) frame();
        probe(224, "t4_second_decay_row7", {PEAK, 24'h0});

        bus.mode = 2'd2;
        lv = '0;
        lv[0 +: LW] = 5'd2;
        strobe(lv);
        frame();
        lv[0 +: LW] = 5'd6;
        bus.levels = lv;
        bus.level_valid = 1'b1;
        bus.ram_address = '0;
        cyc();
        nt = int'(bus.frame_tick);
        bus.level_valid = 1'b0;
        repeat (4) begin
            cyc();
            nt += int'(bus.frame_tick);
        end
        bus.ram_address = 9'd96;
        cyc();
        nt += int'(bus.frame_tick);
        check("t5_one_tick_on_dwell", 48'(nt), 48'd1);
        check("t5_old_level_shown", bus.ram_data, 48'h0);
        frame();
        probe(96, "t5_new_level_row3", {cb, 24'h0});
        probe(160, "t5_new_level_row5", {cb, 24'h0});
        probe(192, "t5_new_level_row6", 48'h0);

        bus.mode = 2'd0;
        bus.on_off = 1'b1;
        probe(77, "t6_home_on", HOME);
        bus.on_off = 1'b0;
        probe(77, "t6_home_off", 48'h0);
        bus.mode = 2'd1;
        lv = '0;
        lv[0 +: LW] = 5'd31;
        strobe(lv);
        frame();
        probe(511, "t6_party_sat_col31_row15", {cb, cb});
        probe(31, "t6_party_sat_col31_row0", {cb, cb});

        for (int it = 0; it < 30; it++) begin
            bus.mode = 2'($urandom_range(0, 3));
            bus.on_off = 1'($urandom_range(0, 1));
            for (int a = 0; a < 512; a++) begin
                bus.ram_address = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 511)) : AW'(a);
                if ($urandom_range(0, 150) == 0) begin
                    for (int b = 0; b < NB; b++) bus.levels[b*LW +: LW] = 5'($urandom_range(0, 31));
                    bus.level_valid = 1'b1;
                end else begin
                    bus.level_valid = 1'b0;
                end
                if ($urandom_range(0, 600) == 0) bus.mode = 2'($urandom_range(0, 3));
                if (it == 15 && a == 250) rst_n = 1'b0;
                if (it == 15 && a == 253) rst_n = 1'b1;
                cyc();
            end
            bus.level_valid = 1'b0;
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
